// File: rtl/prio_encoder_pipe_if.sv
// Request/result bundle for prio_encoder_pipe.
// The slave modport is the encoder; the master modport is whoever
// supplies request vectors and consumes results.
interface prio_encoder_pipe_if #(
    parameter int WIDTH = 8
) ();
    // Index width derived from WIDTH, kept identical to the encoder's own.
    localparam int IDX_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_req;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] out_onehot;
    logic             out_any;

    modport master (
        output in_valid,
        output in_req,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  out_any
    );

    modport slave (
        input  in_valid,
        input  in_req,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output out_any
    );
endinterface

// File: rtl/prio_encoder_pipe.sv
// Registered priority encoder with valid/ready on both sides.
// Compresses a WIDTH-bit request vector into a binary index, a one-hot
// grant and an "any" flag. MODE selects fixed LSB-first (0), fixed
// MSB-first (1) or round-robin (2). One result register stage.
module prio_encoder_pipe #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    prio_encoder_pipe_if.slave  bus
);
    localparam int IDX_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Index of the highest set bit; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] highest_set(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // State
    logic             out_valid_q,  out_valid_d;
    logic [IDX_W-1:0] out_idx_q,    out_idx_d;
    logic [WIDTH-1:0] out_onehot_q, out_onehot_d;
    logic             out_any_q,    out_any_d;
    logic [IDX_W-1:0] ptr_q,        ptr_d;

    // Combinational encode
    logic             in_ready;
    logic             accept;
    logic             transfer;
    logic             req_any;
    logic [WIDTH-1:0] rr_mask;
    logic [WIDTH-1:0] rr_masked_req;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_onehot;

    // The register can take a new result when empty or being drained.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign transfer = out_valid_q && bus.out_ready;
    assign req_any  = |bus.in_req;

    // Round-robin mask: keep only requests at or above the pointer.
    // If none survive, the search wraps and the plain lowest bit wins.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rr_mask
        assign rr_mask[gi] = (IDX_W'(gi) >= ptr_q);
    end
    assign rr_masked_req = bus.in_req & rr_mask;

    // Winner selection by priority mode.
    always_comb begin
        win_idx = '0;
        if (MODE == 1) begin
            win_idx = highest_set(bus.in_req);
        end else if (MODE == 2) begin
            if (|rr_masked_req) win_idx = lowest_set(rr_masked_req);
            else                win_idx = lowest_set(bus.in_req);
        end else begin
            win_idx = lowest_set(bus.in_req);
        end
    end

    // One-hot grant; all zero when there is no request.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
        assign win_onehot[gi] = req_any && (win_idx == IDX_W'(gi));
    end

    // Next state for the result register and the round-robin pointer.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        out_any_d    = out_any_q;
        ptr_d        = ptr_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            out_idx_d    = win_idx;
            out_onehot_d = win_onehot;
            out_any_d    = req_any;
        end else if (transfer) begin
            out_valid_d  = 1'b0;
        end

        // Pointer moves just past the winner; an empty request leaves it.
        if ((MODE == 2) && accept && req_any) begin
            if (win_idx == LAST_IDX) ptr_d = '0;
            else                     ptr_d = win_idx + IDX_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            out_any_q    <= 1'b0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            out_any_q    <= out_any_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_onehot = out_onehot_q;
    assign bus.out_any    = out_any_q;
endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Testbench for prio_encoder_pipe: five instances covering fixed LSB,
// fixed MSB, narrow LSB, round-robin and non-power-of-two round-robin.
module tb_prio_encoder_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    prio_encoder_pipe_if #(.WIDTH(8)) if_a ();
    prio_encoder_pipe_if #(.WIDTH(8)) if_b ();
    prio_encoder_pipe_if #(.WIDTH(4)) if_c ();
    prio_encoder_pipe_if #(.WIDTH(8)) if_d ();
    prio_encoder_pipe_if #(.WIDTH(5)) if_e ();

    prio_encoder_pipe #(.WIDTH(8), .MODE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    prio_encoder_pipe #(.WIDTH(8), .MODE(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    prio_encoder_pipe #(.WIDTH(4), .MODE(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
    prio_encoder_pipe #(.WIDTH(8), .MODE(2)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));
    prio_encoder_pipe #(.WIDTH(5), .MODE(2)) u_e (.clk(clk), .rst_n(rst_n), .bus(if_e.slave));

    // Per-instance configuration for the soak model.
    int cfg_w    [5] = '{8, 8, 4, 8, 5};
    int cfg_mode [5] = '{0, 1, 0, 2, 2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_k(input int k, input logic vld, input logic rdy, input logic [63:0] req);
        case (k)
            0: begin if_a.in_valid = vld; if_a.out_ready = rdy; if_a.in_req = req[7:0]; end
            1: begin if_b.in_valid = vld; if_b.out_ready = rdy; if_b.in_req = req[7:0]; end
            2: begin if_c.in_valid = vld; if_c.out_ready = rdy; if_c.in_req = req[3:0]; end
            3: begin if_d.in_valid = vld; if_d.out_ready = rdy; if_d.in_req = req[7:0]; end
            default: begin if_e.in_valid = vld; if_e.out_ready = rdy; if_e.in_req = req[4:0]; end
        endcase
    endtask

    task automatic sample_k(input int k, output logic ir, output logic ov, output logic oa,
                            output int idx, output logic [63:0] oh);
        case (k)
            0: begin ir = if_a.in_ready; ov = if_a.out_valid; oa = if_a.out_any;
                     idx = int'(if_a.out_idx); oh = 64'(if_a.out_onehot); end
            1: begin ir = if_b.in_ready; ov = if_b.out_valid; oa = if_b.out_any;
                     idx = int'(if_b.out_idx); oh = 64'(if_b.out_onehot); end
            2: begin ir = if_c.in_ready; ov = if_c.out_valid; oa = if_c.out_any;
                     idx = int'(if_c.out_idx); oh = 64'(if_c.out_onehot); end
            3: begin ir = if_d.in_ready; ov = if_d.out_valid; oa = if_d.out_any;
                     idx = int'(if_d.out_idx); oh = 64'(if_d.out_onehot); end
            default: begin ir = if_e.in_ready; ov = if_e.out_valid; oa = if_e.out_any;
                     idx = int'(if_e.out_idx); oh = 64'(if_e.out_onehot); end
        endcase
    endtask

    task automatic idle_all();
        for (int k = 0; k < 5; k++) drive_k(k, 1'b0, 1'b1, 64'd0);
    endtask

    // Reference winner: -1 when no request is set.
    function automatic int ref_win(input int w, input int mode, input int ptr, input logic [63:0] req);
        if (mode == 0) begin
            for (int i = 0; i < w; i++) if (req[i]) return i;
        end else if (mode == 1) begin
            for (int i = w - 1; i >= 0; i--) if (req[i]) return i;
        end else begin
            for (int j = 0; j < w; j++) if (req[(ptr + j) % w]) return (ptr + j) % w;
        end
        return -1;
    endfunction

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        if_a.in_valid = 1'b1; if_a.in_req = 8'hA8; if_a.out_ready = 1'b0;
        tick();
        if_a.in_valid = 1'b0;
        tests_run++;
        if ({if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot} !== {1'b1, 1'b1, 3'd3, 8'h08}) begin
            tests_failed++;
            $display("FAIL reset_preload: got v=%b any=%b idx=%0d oh=%h, want v=1 any=1 idx=3 oh=08",
                     if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot);
        end
        $display("[TB] reset_preload checked");
        // Assert reset between clock edges; outputs must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got v=%b any=%b idx=%0d oh=%h, want all 0",
                     if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot);
        end
        $display("[TB] reset_async checked");
        tick();
        rst_n = 1'b1;
        // Zero input is a valid, handshaked result.
        if_a.in_valid = 1'b1; if_a.in_req = 8'h00; if_a.out_ready = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        tests_run++;
        if ({if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot} !== {1'b1, 1'b0, 3'd0, 8'h00}) begin
            tests_failed++;
            $display("FAIL zero_input: got v=%b any=%b idx=%0d oh=%h, want v=1 any=0 idx=0 oh=00",
                     if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot);
        end
        $display("[TB] zero_input checked");
        tick();
    endtask

    task automatic test_fixed();
        logic [7:0] reqs  [4] = '{8'hA8, 8'h01, 8'h80, 8'h0C};
        logic [2:0] a_idx [4] = '{3'd3, 3'd0, 3'd7, 3'd2};
        logic [7:0] a_oh  [4] = '{8'h08, 8'h01, 8'h80, 8'h04};
        logic [2:0] b_idx [4] = '{3'd7, 3'd0, 3'd7, 3'd3};
        logic [7:0] b_oh  [4] = '{8'h80, 8'h01, 8'h80, 8'h08};
        for (int t = 0; t < 4; t++) begin
            drive_k(0, 1'b1, 1'b1, 64'(reqs[t]));
            drive_k(1, 1'b1, 1'b1, 64'(reqs[t]));
            tick();
            tests_run++;
            if ({if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot} !== {1'b1, 1'b1, a_idx[t], a_oh[t]}) begin
                tests_failed++;
                $display("FAIL fixed_lsb req=%h: got idx=%0d oh=%h any=%b, want idx=%0d oh=%h any=1",
                         reqs[t], if_a.out_idx, if_a.out_onehot, if_a.out_any, a_idx[t], a_oh[t]);
            end
            tests_run++;
            if ({if_b.out_valid, if_b.out_any, if_b.out_idx, if_b.out_onehot} !== {1'b1, 1'b1, b_idx[t], b_oh[t]}) begin
                tests_failed++;
                $display("FAIL fixed_msb req=%h: got idx=%0d oh=%h any=%b, want idx=%0d oh=%h any=1",
                         reqs[t], if_b.out_idx, if_b.out_onehot, if_b.out_any, b_idx[t], b_oh[t]);
            end
            $display("[TB] fixed req=%h lsb_idx=%0d msb_idx=%0d", reqs[t], if_a.out_idx, if_b.out_idx);
        end
        idle_all();
        tick();
    endtask

    task automatic test_sweep_w4();
        logic [1:0] exp_idx [16] = '{0,0,1,0,2,0,1,0,3,0,1,0,2,0,1,0};
        logic [3:0] exp_oh  [16] = '{0,1,2,1,4,1,2,1,8,1,2,1,4,1,2,1};
        for (int r = 0; r < 16; r++) begin
            drive_k(2, 1'b1, 1'b1, 64'(r));
            tick();
            tests_run++;
            if ({if_c.out_valid, if_c.out_any, if_c.out_idx, if_c.out_onehot} !==
                {1'b1, (r != 0), exp_idx[r], exp_oh[r]}) begin
                tests_failed++;
                $display("FAIL sweep_w4 req=%h: got any=%b idx=%0d oh=%h, want any=%0d idx=%0d oh=%h",
                         r[3:0], if_c.out_any, if_c.out_idx, if_c.out_onehot, (r != 0), exp_idx[r], exp_oh[r]);
            end
            $display("[TB] sweep_w4 req=%h idx=%0d", r[3:0], if_c.out_idx);
        end
        idle_all();
        tick();
    endtask

    task automatic test_backpressure();
        drive_k(0, 1'b1, 1'b0, 64'h30);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive_k(0, 1'b1, 1'b0, 64'($urandom_range(255)));
            #1;
            tests_run++;
            if (if_a.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_in_ready cycle %0d: got %b, want 0", c, if_a.in_ready);
            end
            tick();
            tests_run++;
            if ({if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot} !== {1'b1, 1'b1, 3'd4, 8'h10}) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: got v=%b idx=%0d oh=%h, want v=1 idx=4 oh=10",
                         c, if_a.out_valid, if_a.out_idx, if_a.out_onehot);
            end
            $display("[TB] bp_hold cycle %0d idx=%0d", c, if_a.out_idx);
        end
        drive_k(0, 1'b1, 1'b1, 64'h06);
        #1;
        tests_run++;
        if (if_a.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b, want 1", if_a.in_ready);
        end
        tick();
        tests_run++;
        if ({if_a.out_valid, if_a.out_any, if_a.out_idx, if_a.out_onehot} !== {1'b1, 1'b1, 3'd1, 8'h02}) begin
            tests_failed++;
            $display("FAIL bp_replace: got v=%b idx=%0d oh=%h, want v=1 idx=1 oh=02",
                     if_a.out_valid, if_a.out_idx, if_a.out_onehot);
        end
        $display("[TB] bp_replace idx=%0d", if_a.out_idx);
        drive_k(0, 1'b0, 1'b1, 64'd0);
        tick();
        tests_run++;
        if (if_a.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain: got out_valid=%b, want 0", if_a.out_valid);
        end
        $display("[TB] bp_drain valid=%b", if_a.out_valid);
    endtask

    task automatic test_round_robin();
        logic [7:0] reqs [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                  8'h05, 8'h05, 8'h05, 8'h00, 8'hFF};
        int         exp  [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 2, 0, 2, -1, 3};
        logic [7:0] e_oh;
        logic [2:0] e_idx;
        for (int t = 0; t < 14; t++) begin
            drive_k(3, 1'b1, 1'b1, 64'(reqs[t]));
            tick();
            e_idx = (exp[t] < 0) ? 3'd0 : 3'(exp[t]);
            e_oh  = (exp[t] < 0) ? 8'h00 : (8'h01 << exp[t]);
            tests_run++;
            if ({if_d.out_valid, if_d.out_any, if_d.out_idx, if_d.out_onehot} !== {1'b1, (exp[t] >= 0), e_idx, e_oh}) begin
                tests_failed++;
                $display("FAIL rr_w8 step %0d req=%h: got any=%b idx=%0d oh=%h, want any=%0d idx=%0d oh=%h",
                         t, reqs[t], if_d.out_any, if_d.out_idx, if_d.out_onehot, (exp[t] >= 0), e_idx, e_oh);
            end
            $display("[TB] rr_w8 step %0d req=%h idx=%0d any=%b", t, reqs[t], if_d.out_idx, if_d.out_any);
        end
        idle_all();
        tick();
    endtask

    task automatic test_rr_wrap_w5();
        logic [4:0] reqs [6] = '{5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10000, 5'b00110};
        logic [2:0] exp  [6] = '{3'd0, 3'd4, 3'd0, 3'd4, 3'd4, 3'd1};
        logic [4:0] e_oh;
        for (int t = 0; t < 6; t++) begin
            drive_k(4, 1'b1, 1'b1, 64'(reqs[t]));
            tick();
            e_oh = 5'b00001 << exp[t];
            tests_run++;
            if ({if_e.out_valid, if_e.out_any, if_e.out_idx, if_e.out_onehot} !== {1'b1, 1'b1, exp[t], e_oh}) begin
                tests_failed++;
                $display("FAIL rr_w5 step %0d req=%b: got idx=%0d oh=%b, want idx=%0d oh=%b",
                         t, reqs[t], if_e.out_idx, if_e.out_onehot, exp[t], e_oh);
            end
            $display("[TB] rr_w5 step %0d req=%b idx=%0d", t, reqs[t], if_e.out_idx);
        end
        idle_all();
        tick();
    endtask

    task automatic test_soak();
        int          ring   [5][16];
        int          wr_cnt [5];
        int          rd_cnt [5];
        int          ptr    [5];
        int          xfers  [5];
        logic        vld, rdy, ir, ov, oa;
        logic [63:0] req, oh, e_oh;
        int          idx, exp_w;
        idle_all();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_cnt[k] = 0; rd_cnt[k] = 0; ptr[k] = 0; xfers[k] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            vld = 1'($urandom_range(1));
            rdy = ($urandom_range(3) != 0);
            req = {$urandom(), $urandom()};
            if ($urandom_range(7) == 0) req = 64'd0;
            for (int k = 0; k < 5; k++) drive_k(k, vld, rdy, req);
            #1;
            for (int k = 0; k < 5; k++) begin
                sample_k(k, ir, ov, oa, idx, oh);
                tests_run++;
                if (!((oh === (oa ? (64'd1 << idx) : 64'd0)) && (idx < cfg_w[k]) && (ir === (!ov || rdy)))) begin
                    tests_failed++;
                    $display("FAIL soak_invariant inst %0d cycle %0d: got ready=%b any=%b idx=%0d oh=%h",
                             k, cyc, ir, oa, idx, oh);
                end
                if (ov && rdy) begin
                    tests_run++;
                    if (rd_cnt[k] == wr_cnt[k]) begin
                        tests_failed++;
                        $display("FAIL soak_spurious inst %0d cycle %0d: got transfer with nothing accepted", k, cyc);
                    end else begin
                        exp_w = ring[k][rd_cnt[k] % 16];
                        rd_cnt[k]++;
                        e_oh  = (exp_w < 0) ? 64'd0 : (64'd1 << exp_w);
                        if ({oa, idx, oh} !== {(exp_w >= 0), ((exp_w < 0) ? 0 : exp_w), e_oh}) begin
                            tests_failed++;
                            $display("FAIL soak_result inst %0d cycle %0d: got any=%b idx=%0d oh=%h, want win=%0d",
                                     k, cyc, oa, idx, oh, exp_w);
                        end
                    end
                    xfers[k]++;
                end
                if (vld && (!ov || rdy)) begin
                    exp_w = ref_win(cfg_w[k], cfg_mode[k], ptr[k], req & ((64'd1 << cfg_w[k]) - 64'd1));
                    ring[k][wr_cnt[k] % 16] = exp_w;
                    wr_cnt[k]++;
                    if (cfg_mode[k] == 2 && exp_w >= 0) ptr[k] = (exp_w + 1) % cfg_w[k];
                end
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            sample_k(k, ir, ov, oa, idx, oh);
            tests_run++;
            if ((wr_cnt[k] - rd_cnt[k]) != (ov ? 1 : 0)) begin
                tests_failed++;
                $display("FAIL soak_occupancy inst %0d: got %0d outstanding with out_valid=%b",
                         k, wr_cnt[k] - rd_cnt[k], ov);
            end
            $display("[TB] soak inst %0d accepted=%0d transferred=%0d", k, wr_cnt[k], xfers[k]);
        end
        idle_all();
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_fixed();
        test_sweep_w4();
        test_backpressure();
        test_round_robin();
        test_rr_wrap_w5();
        test_soak();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
